// File: rtl/frame_mux_pkg.sv
// Shared types for the frame-synchronous source selector: the applied-state
// encoding and the selection request record held in the pending register.
package frame_mux_pkg;

    // Widest buffer index ever needed (up to 16 buffers).
    localparam int MAX_SEL_W = 4;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_e;

    typedef struct packed {
        logic                 blank;
        logic [MAX_SEL_W-1:0] idx;
    } sel_req_t;

    // A request is usable when it asks for blank or names an existing buffer.
    function automatic logic req_is_legal(input logic blank,
                                          input logic [MAX_SEL_W-1:0] idx,
                                          input int num_buf);
        return blank || (int'(idx) < num_buf);
    endfunction

endpackage

// File: rtl/frame_mux_sel_ctrl.sv
// Selection control: latches requests, applies them only at frame boundaries,
// and raises the SwapAck / SelErr pulses. Also exports the selection that is
// in force for the current cycle so the datapath can bypass on FrameStart.
module frame_mux_sel_ctrl
    import frame_mux_pkg::*;
#(
    parameter int NUM_BUF = 2,
    parameter int SEL_W   = 1
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             frame_start_i,
    input  logic             req_valid_i,
    input  logic             req_blank_i,
    input  logic [SEL_W-1:0] req_idx_i,
    output logic             eff_blank_o,
    output logic [SEL_W-1:0] eff_sel_o,
    output logic             blanked_o,
    output logic [SEL_W-1:0] active_sel_o,
    output logic             pending_o,
    output logic             swap_ack_o,
    output logic             sel_err_o
);

    state_e           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             pend_valid_q, pend_valid_d;
    sel_req_t         pend_req_q, pend_req_d;
    logic             swap_ack_q;
    logic             sel_err_q;

    sel_req_t new_req;
    sel_req_t apply_req;
    logic     req_legal;
    logic     req_illegal;
    logic     apply;
    // Upper index bits are always zero for legal requests; only the low
    // SEL_W bits drive the selection.
    logic     unused_idx_bits;

    assign new_req.blank = req_blank_i;
    assign new_req.idx   = MAX_SEL_W'(req_idx_i);

    assign req_legal   = req_valid_i &&  req_is_legal(req_blank_i, new_req.idx, NUM_BUF);
    assign req_illegal = req_valid_i && !req_is_legal(req_blank_i, new_req.idx, NUM_BUF);

    // A same-cycle legal request beats the older pending one.
    assign apply     = frame_start_i && (pend_valid_q || req_legal);
    assign apply_req = req_legal ? new_req : pend_req_q;

    assign unused_idx_bits = ^apply_req.idx;

    // Next applied selection and pending-register update.
    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        pend_valid_d = pend_valid_q;
        pend_req_d   = pend_req_q;
        if (apply) begin
            state_d      = apply_req.blank ? ST_BLANK : ST_SHOW;
            if (!apply_req.blank) begin
                sel_d = apply_req.idx[SEL_W-1:0];
            end
            pend_valid_d = 1'b0;
        end else if (req_legal) begin
            pend_valid_d = 1'b1;
            pend_req_d   = new_req;
        end
    end

    // Applied selection, pending request and status pulses.
    always_ff @(posedge clk) begin
        if (srst) begin
            state_q      <= ST_BLANK;
            sel_q        <= '0;
            pend_valid_q <= 1'b0;
            pend_req_q   <= '0;
            swap_ack_q   <= 1'b0;
            sel_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            pend_valid_q <= pend_valid_d;
            pend_req_q   <= pend_req_d;
            swap_ack_q   <= apply;
            sel_err_q    <= req_illegal;
        end
    end

    // The next-state selection is already valid on the FrameStart cycle.
    assign eff_blank_o  = (state_d == ST_BLANK);
    assign eff_sel_o    = sel_d;
    assign blanked_o    = (state_q == ST_BLANK);
    assign active_sel_o = sel_q;
    assign pending_o    = pend_valid_q;
    assign swap_ack_o   = swap_ack_q;
    assign sel_err_o    = sel_err_q;

endmodule

// File: rtl/frame_mux_seq.sv
// Registered frame-synchronous source selector: picks one of NUM_BUF pixel
// buffers or the blank level, switching only at FrameStart.
// Optional build macro FRAME_MUX_TESTPAT_EN: while blanked, output an 8-bit
// ramp that counts PixValid cycles from each FrameStart instead of BLANK_VAL.
module frame_mux_seq
    import frame_mux_pkg::*;
#(
    parameter int                DATA_W    = 8,
    parameter int                NUM_BUF   = 2,
    parameter logic [DATA_W-1:0] BLANK_VAL = '0,
    localparam int               SEL_W     = (NUM_BUF > 1) ? $clog2(NUM_BUF) : 1
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic [NUM_BUF*DATA_W-1:0] BufData,
    input  logic                      PixValid,
    input  logic                      FrameStart,
    input  logic                      SelReqValid,
    input  logic                      SelReqBlank,
    input  logic [SEL_W-1:0]          SelReqIdx,
    output logic [DATA_W-1:0]         FrameIn,
    output logic                      FrameValid,
    output logic [SEL_W-1:0]          ActiveSel,
    output logic                      Blanked,
    output logic                      Pending,
    output logic                      SwapAck,
    output logic                      SelErr
);

    localparam int NUM_SLOTS = 1 << SEL_W;

    logic             eff_blank;
    logic [SEL_W-1:0] eff_sel;
    logic [DATA_W-1:0] buf_arr [NUM_SLOTS];
    logic [DATA_W-1:0] blank_pix;
    logic [DATA_W-1:0] frame_in_q, frame_in_d;
    logic              frame_valid_q;

    frame_mux_sel_ctrl #(
        .NUM_BUF (NUM_BUF),
        .SEL_W   (SEL_W)
    ) u_sel_ctrl (
        .clk           (Clk),
        .srst          (Reset),
        .frame_start_i (FrameStart),
        .req_valid_i   (SelReqValid),
        .req_blank_i   (SelReqBlank),
        .req_idx_i     (SelReqIdx),
        .eff_blank_o   (eff_blank),
        .eff_sel_o     (eff_sel),
        .blanked_o     (Blanked),
        .active_sel_o  (ActiveSel),
        .pending_o     (Pending),
        .swap_ack_o    (SwapAck),
        .sel_err_o     (SelErr)
    );

    // Unpack the buffer bus; unused slots (non power-of-two NUM_BUF) read zero.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
            if (gi < NUM_BUF) begin : g_used
                assign buf_arr[gi] = BufData[gi*DATA_W +: DATA_W];
            end else begin : g_pad
                assign buf_arr[gi] = '0;
            end
        end
    endgenerate

`ifdef FRAME_MUX_TESTPAT_EN
    logic [7:0] ramp_q, ramp_d, ramp_cur;

    // Pixel index within the frame: zero on the FrameStart pixel itself.
    assign ramp_cur  = FrameStart ? 8'd0 : ramp_q;
    assign ramp_d    = ramp_cur + {7'd0, PixValid};
    assign blank_pix = DATA_W'(ramp_cur);

    // Ramp counter advances once per valid pixel slot.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            ramp_q <= 8'd0;
        end else begin
            ramp_q <= ramp_d;
        end
    end
`else
    assign blank_pix = BLANK_VAL;
`endif

    // Source mux; uses the selection in force this cycle (bypassed at FrameStart).
    always_comb begin
        frame_in_d = eff_blank ? blank_pix : buf_arr[eff_sel];
    end

    // One-cycle output register for pixel and valid.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            frame_in_q    <= BLANK_VAL;
            frame_valid_q <= 1'b0;
        end else begin
            frame_in_q    <= frame_in_d;
            frame_valid_q <= PixValid;
        end
    end

    assign FrameIn    = frame_in_q;
    assign FrameValid = frame_valid_q;

endmodule

// File: tb/tb_frame_mux_seq.sv
// Self-checking bench for frame_mux_seq (NUM_BUF=3, DATA_W=8, BLANK_VAL=8'h5A):
// directed scenarios with literal expectations, then randomized traffic
// checked every cycle against a behavioural model of the selector.
module tb_frame_mux_seq;

    localparam int         DATA_W  = 8;
    localparam int         NUM_BUF = 3;
    localparam logic [7:0] BLANK   = 8'h5A;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] buf_data;
    logic        pix_valid;
    logic        frame_start;
    logic        req_valid;
    logic        req_blank;
    logic [1:0]  req_idx;
    logic [7:0]  frame_in;
    logic        frame_valid;
    logic [1:0]  active_sel;
    logic        blanked;
    logic        pending;
    logic        swap_ack;
    logic        sel_err;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int ack_cnt   = 0;

    // Behavioural model state
    logic       m_blank, m_pend, m_pblank;
    logic [1:0] m_sel, m_pidx;
    logic [7:0] m_ramp;
    // Expected outputs after the coming edge
    logic [7:0] e_frame;
    logic       e_valid, e_blanked, e_pend, e_ack, e_err;
    logic [1:0] e_sel;

    frame_mux_seq #(
        .DATA_W    (DATA_W),
        .NUM_BUF   (NUM_BUF),
        .BLANK_VAL (BLANK)
    ) dut (
        .Clk         (clk),
        .Reset       (rst),
        .BufData     (buf_data),
        .PixValid    (pix_valid),
        .FrameStart  (frame_start),
        .SelReqValid (req_valid),
        .SelReqBlank (req_blank),
        .SelReqIdx   (req_idx),
        .FrameIn     (frame_in),
        .FrameValid  (frame_valid),
        .ActiveSel   (active_sel),
        .Blanked     (blanked),
        .Pending     (pending),
        .SwapAck     (swap_ack),
        .SelErr      (sel_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Advance the model by one cycle using the current inputs, clock the DUT,
    // then compare every output against the model.
    task automatic step();
        logic       legal;
        logic [7:0] pix_idx;
        logic [7:0] blank_pix;
        if (req_valid)
            $display("req t=%0t blank=%0b idx=%0d fs=%0b", $time, req_blank, req_idx, frame_start);
        if (rst) begin
            m_blank = 1'b1; m_sel = 2'd0; m_pend = 1'b0; m_ramp = 8'd0;
            e_frame = BLANK; e_valid = 1'b0; e_sel = 2'd0; e_blanked = 1'b1;
            e_pend = 1'b0; e_ack = 1'b0; e_err = 1'b0;
        end else begin
            legal = req_valid && (req_blank || (int'(req_idx) < NUM_BUF));
            e_err = req_valid && !legal;
            e_ack = 1'b0;
            if (frame_start && (legal || m_pend)) begin
                if (legal) begin
                    m_blank = req_blank;
                    if (!req_blank) m_sel = req_idx;
                end else begin
                    m_blank = m_pblank;
                    if (!m_pblank) m_sel = m_pidx;
                end
                m_pend = 1'b0;
                e_ack  = 1'b1;
            end else if (legal) begin
                m_pend = 1'b1; m_pblank = req_blank; m_pidx = req_idx;
            end
            pix_idx = frame_start ? 8'd0 : m_ramp;
            m_ramp  = pix_idx + 8'(pix_valid);
`ifdef FRAME_MUX_TESTPAT_EN
            blank_pix = pix_idx;
`else
            blank_pix = BLANK;
`endif
            e_frame   = m_blank ? blank_pix : buf_data[m_sel*8 +: 8];
            e_valid   = pix_valid;
            e_sel     = m_sel;
            e_blanked = m_blank;
            e_pend    = m_pend;
        end
        @(posedge clk);
        #1;
        if (swap_ack) ack_cnt++;
        chk("FrameIn",    32'(frame_in),    32'(e_frame));
        chk("FrameValid", 32'(frame_valid), 32'(e_valid));
        chk("ActiveSel",  32'(active_sel),  32'(e_sel));
        chk("Blanked",    32'(blanked),     32'(e_blanked));
        chk("Pending",    32'(pending),     32'(e_pend));
        chk("SwapAck",    32'(swap_ack),    32'(e_ack));
        chk("SelErr",     32'(sel_err),     32'(e_err));
    endtask

    task automatic idle();
        req_valid = 1'b0; frame_start = 1'b0;
    endtask

    task automatic request(input logic blank, input logic [1:0] idx);
        req_valid = 1'b1; req_blank = blank; req_idx = idx;
    endtask

    initial begin
        rst = 1'b1; buf_data = {8'hCC, 8'hBB, 8'hAA}; pix_valid = 1'b1;
        frame_start = 1'b0; req_valid = 1'b0; req_blank = 1'b0; req_idx = 2'd0;
        step(); step();
        chk("reset_FrameIn",    32'(frame_in),    32'h5A);
        chk("reset_Blanked",    32'(blanked),     32'd1);
        chk("reset_FrameValid", 32'(frame_valid), 32'd0);
        rst = 1'b0;

        // No request: stays blank, no acknowledge.
        for (int i = 0; i < 5; i++) step();
`ifndef FRAME_MUX_TESTPAT_EN
        chk("noreq_FrameIn", 32'(frame_in), 32'h5A);
`endif
        chk("noreq_acks", 32'(ack_cnt), 32'd0);

        // idx=1 mid-frame, FrameStart ten cycles later.
        request(1'b0, 2'd1); step(); idx_hold: idle();
        for (int i = 0; i < 10; i++) begin
            step();
            chk("pend_hold", 32'(pending), 32'd1);
        end
        frame_start = 1'b1; step(); idle();
        chk("swap_FrameIn", 32'(frame_in),   32'hBB);
        chk("swap_Ack",     32'(swap_ack),   32'd1);
        chk("swap_Sel",     32'(active_sel), 32'd1);
        step();
        chk("swap_AckPulse", 32'(swap_ack), 32'd0);
        chk("swap_acks",     32'(ack_cnt),  32'd1);

        // idx=0 then blank before the boundary: only blank is applied.
        request(1'b0, 2'd0); step();
        request(1'b1, 2'd3); step(); idle();
        frame_start = 1'b1; step(); idle();
        chk("lastwins_Blanked", 32'(blanked),    32'd1);
        chk("lastwins_Sel",     32'(active_sel), 32'd1);
`ifndef FRAME_MUX_TESTPAT_EN
        chk("lastwins_FrameIn", 32'(frame_in),   32'h5A);
`endif

        // Illegal index, then same-cycle request beating a pending one.
        request(1'b0, 2'd3); step(); idle();
        chk("illegal_Err",  32'(sel_err), 32'd1);
        chk("illegal_Pend", 32'(pending), 32'd0);
        request(1'b0, 2'd0); step();
        request(1'b0, 2'd3); step(); idle();
        chk("illegal_Pend2", 32'(pending), 32'd1);
        request(1'b0, 2'd2); frame_start = 1'b1; step(); idle();
        chk("samecyc_Sel",     32'(active_sel), 32'd2);
        chk("samecyc_FrameIn", 32'(frame_in),   32'hCC);

        // Reset mid-frame with a request pending.
        request(1'b0, 2'd1); step(); idle();
        rst = 1'b1; step(); rst = 1'b0;
        chk("midrst_Pend",    32'(pending),  32'd0);
        chk("midrst_Blanked", 32'(blanked),  32'd1);
        chk("midrst_FrameIn", 32'(frame_in), 32'h5A);
        frame_start = 1'b1; step(); idle();
        chk("midrst_NoAck",   32'(swap_ack), 32'd0);

`ifdef FRAME_MUX_TESTPAT_EN
        // Blanked ramp: 0..4 across the first five valid pixels.
        step();
        frame_start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            frame_start = 1'b0;
            chk("ramp", 32'(frame_in), 32'(i));
        end
`endif

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            buf_data    = 24'($urandom());
            pix_valid   = ($urandom_range(0, 3) != 0);
            frame_start = ($urandom_range(0, 11) == 0);
            req_valid   = ($urandom_range(0, 7) == 0);
            req_blank   = ($urandom_range(0, 3) == 0);
            req_idx     = 2'($urandom_range(0, 3));
            rst         = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0; idle();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
